// File: rtl/rx_dump_ring.sv
// Receive packet capture ring: filtered, snap-length-limited packet storage with
// whole-packet rollback and a descriptor FIFO retired by the host.
module rx_dump_ring #(
    parameter int DATA_W  = 32,
    parameter int MOD_W   = 2,
    parameter int ADDR_W  = 12,
    parameter int INFO_AW = 4,
    parameter int STAT_W  = 64
) (
    input  logic                      in_clk,
    input  logic                      rst_n,
    input  logic                      cfg_en,
    input  logic [1:0]                cfg_mode,
    input  logic [7:0]                cfg_code,
    input  logic [ADDR_W-1:0]         cfg_snap,
    input  logic                      in_valid,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic [MOD_W-1:0]          in_mod,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [STAT_W-1:0]         in_stat,
    input  logic                      rd_buf,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W+MOD_W+1:0]   rd_data,
    output logic                      info_vald,
    output logic [ADDR_W-1:0]         info_base,
    output logic [15:0]               info_len,
    output logic                      info_trunc,
    output logic [STAT_W-1:0]         info_stat,
    input  logic                      info_pop,
    output logic [15:0]               cap_cnt,
    output logic [15:0]               drop_cnt
);
    localparam int BEAT_W = DATA_W + MOD_W + 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FDEPTH = 1 << INFO_AW;
    localparam logic [16:0] BEAT_BYTES = 17'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, CAPT, SKIP, DROP} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cur_ptr, cur_next, wr_ptr, wr_next, head_ptr;
    logic [ADDR_W-1:0]   base_reg, base_next, stored_reg, stored_next;
    logic [15:0]         bytes_reg, bytes_next;
    logic                trunc_reg, trunc_next;

    logic [BEAT_W-1:0]   ring_mem [DEPTH];
    logic [ADDR_W-1:0]   base_mem [FDEPTH];
    logic [ADDR_W-1:0]   end_mem  [FDEPTH];
    logic [15:0]         len_mem  [FDEPTH];
    logic                trunc_mem[FDEPTH];
    logic [STAT_W-1:0]   stat_mem [FDEPTH];
    logic [INFO_AW-1:0]  fifo_rd, fifo_wr;
    logic [INFO_AW:0]    fifo_cnt;

    logic                abort, ring_we, push, cap_inc, fin, fin_trunc, filter_pass, pop_ok;
    logic [1:0]          drop_add;
    state_t              eff_state;
    logic [ADDR_W-1:0]   eff_cur, fin_end, fin_base, stored_inc;
    logic [16:0]         byte_base, last_bytes, len_sum, bytes_inc;
    logic [15:0]         len_sat;
    logic                ring_full, fifo_full;
    logic [16:0]         drop_sum;

    assign fifo_full  = fifo_cnt[INFO_AW];
    assign info_vald  = (fifo_cnt != '0);
    assign pop_ok     = info_pop && info_vald;
    assign info_base  = info_vald ? base_mem[fifo_rd]  : '0;
    assign info_len   = info_vald ? len_mem[fifo_rd]   : '0;
    assign info_trunc = info_vald ? trunc_mem[fifo_rd] : 1'b0;
    assign info_stat  = info_vald ? stat_mem[fifo_rd]  : '0;

    always_comb begin
        unique case (cfg_mode)
            2'b00:   filter_pass = (in_stat[7:0] == cfg_code);
            2'b01:   filter_pass = 1'b1;
            2'b10:   filter_pass = (in_stat[7:0] != 8'd0);
            default: filter_pass = 1'b0;
        endcase
    end

    // A sop inside a packet rolls back first, then is handled exactly as from IDLE.
    always_comb begin
        abort      = in_valid && in_sop && (state_reg == CAPT || state_reg == SKIP);
        eff_state  = abort ? IDLE : state_reg;
        eff_cur    = abort ? wr_ptr : cur_ptr;
        ring_full  = ((eff_cur - head_ptr) == {ADDR_W{1'b1}});
        byte_base  = (eff_state == IDLE) ? 17'd0 : {1'b0, bytes_reg};
        last_bytes = (in_mod == '0) ? BEAT_BYTES : {{(17-MOD_W){1'b0}}, in_mod};
        len_sum    = byte_base + last_bytes;
        bytes_inc  = byte_base + BEAT_BYTES;
        len_sat    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        stored_inc = stored_reg + 1'b1;

        state_next  = state_reg;
        cur_next    = cur_ptr;
        wr_next     = wr_ptr;
        base_next   = base_reg;
        stored_next = stored_reg;
        bytes_next  = bytes_reg;
        trunc_next  = trunc_reg;
        ring_we     = 1'b0;
        push        = 1'b0;
        cap_inc     = 1'b0;
        drop_add    = 2'd0;
        fin         = 1'b0;
        fin_end     = eff_cur;
        fin_base    = base_reg;
        fin_trunc   = trunc_reg;

        if (in_valid) begin
            if (abort) begin
                drop_add   = 2'd1;
                cur_next   = wr_ptr;
                state_next = IDLE;
            end
            unique case (eff_state)
                IDLE: if (in_sop && cfg_en) begin
                    base_next  = eff_cur;
                    trunc_next = 1'b0;
                    bytes_next = bytes_inc[16] ? 16'hFFFF : bytes_inc[15:0];
                    if (fifo_full || ring_full) begin
                        if (in_eop) drop_add = drop_add + 2'd1;
                        else        state_next = DROP;
                    end else begin
                        ring_we     = 1'b1;
                        cur_next    = eff_cur + 1'b1;
                        stored_next = {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (in_eop) begin
                            fin = 1'b1; fin_end = eff_cur + 1'b1; fin_base = eff_cur; fin_trunc = 1'b0;
                        end else if (cfg_snap != '0 && cfg_snap <= {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                            state_next = SKIP;
                        end else begin
                            state_next = CAPT;
                        end
                    end
                end
                CAPT: begin
                    if (ring_full) begin
                        if (in_eop) begin
                            drop_add   = drop_add + 2'd1;
                            cur_next   = wr_ptr;
                            state_next = IDLE;
                        end else begin
                            state_next = DROP;
                        end
                    end else begin
                        ring_we     = 1'b1;
                        cur_next    = cur_ptr + 1'b1;
                        stored_next = stored_inc;
                        if (in_eop) begin
                            fin = 1'b1; fin_end = cur_ptr + 1'b1;
                        end else begin
                            bytes_next = bytes_inc[16] ? 16'hFFFF : bytes_inc[15:0];
                            if (cfg_snap != '0 && stored_inc >= cfg_snap) state_next = SKIP;
                        end
                    end
                end
                SKIP: begin
                    trunc_next = 1'b1;
                    if (in_eop) begin
                        fin = 1'b1; fin_end = cur_ptr; fin_trunc = 1'b1;
                    end else begin
                        bytes_next = bytes_inc[16] ? 16'hFFFF : bytes_inc[15:0];
                    end
                end
                default: if (in_eop) begin
                    drop_add   = drop_add + 2'd1;
                    cur_next   = wr_ptr;
                    state_next = IDLE;
                end
            endcase
        end

        if (fin) begin
            state_next = IDLE;
            if (filter_pass) begin
                push     = 1'b1;
                cap_inc  = 1'b1;
                wr_next  = fin_end;
                cur_next = fin_end;
            end else begin
                cur_next = wr_ptr;
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_add};

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cur_ptr    <= '0;
            wr_ptr     <= '0;
            head_ptr   <= '0;
            base_reg   <= '0;
            stored_reg <= '0;
            bytes_reg  <= '0;
            trunc_reg  <= 1'b0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_cnt   <= '0;
            cap_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            state_reg  <= state_next;
            cur_ptr    <= cur_next;
            wr_ptr     <= wr_next;
            base_reg   <= base_next;
            stored_reg <= stored_next;
            bytes_reg  <= bytes_next;
            trunc_reg  <= trunc_next;
            if (pop_ok) begin
                head_ptr <= end_mem[fifo_rd];
                fifo_rd  <= fifo_rd + 1'b1;
            end
            if (push) fifo_wr <= fifo_wr + 1'b1;
            fifo_cnt <= fifo_cnt + (INFO_AW+1)'(push) - (INFO_AW+1)'(pop_ok);
            if (cap_inc && cap_cnt != 16'hFFFF) cap_cnt <= cap_cnt + 1'b1;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge in_clk) begin
        if (ring_we) ring_mem[eff_cur] <= {in_sop, in_eop, in_mod, in_data};
        if (push) begin
            base_mem[fifo_wr]  <= fin_base;
            end_mem[fifo_wr]   <= fin_end;
            len_mem[fifo_wr]   <= len_sat;
            trunc_mem[fifo_wr] <= fin_trunc;
            stat_mem[fifo_wr]  <= in_stat;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n)      rd_data <= '0;
        else if (rd_buf) rd_data <= ring_mem[rd_addr];
    end
endmodule

// File: doc/rx_dump_ring.md
# rx_dump_ring

Parametrised single-clock successor to the rx packet dump buffer: captures selected receive packets into a ring buffer of configurable width and depth, and queues one descriptor per captured packet for the host side. The block adds a programmable capture filter, per-packet snap-length truncation, whole-packet rollback on overflow, and drop/capture counters. It sits on the rx data path after statistics generation, in parallel with the loopback path, and is read by the uP register bank on the same clock.

## Interface
- DATA_W, 32, data beat width; must be a multiple of 8, 8..64
- MOD_W, 2, width of in_mod; equals log2(DATA_W/8), minimum 1
- ADDR_W, 12, ring depth is 2^ADDR_W beats
- INFO_AW, 4, descriptor FIFO depth is 2^INFO_AW
- STAT_W, 64, width of in_stat
- in_clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_en  in  1  capture enable; sampled on the sop beat only
- cfg_mode  in  2  filter: 00 = in_stat[7:0]==cfg_code, 01 = all, 10 = in_stat[7:0]!=0, 11 = none
- cfg_code  in  8  filter code for mode 00
- cfg_snap  in  ADDR_W  maximum stored beats per packet; 0 = no limit
- in_valid, in_sop, in_eop  in  1 each  beat qualifiers
- in_mod  in  MOD_W  valid bytes on the eop beat; 0 = all DATA_W/8
- in_data  in  DATA_W  beat data
- in_stat  in  STAT_W  packet status; valid on the eop beat
- rd_buf  in  1  ring read strobe
- rd_addr  in  ADDR_W  ring read address
- rd_data  out  DATA_W+MOD_W+2  {sop, eop, mod, data} of the addressed beat
- info_vald  out  1  descriptor FIFO not empty (show-ahead)
- info_base  out  ADDR_W  ring address of the first stored beat
- info_len  out  16  received byte length, saturating at 0xFFFF
- info_trunc  out  1  packet was cut at cfg_snap
- info_stat  out  STAT_W  in_stat of the packet
- info_pop  in  1  retire the head descriptor and free its ring space
- cap_cnt, drop_cnt  out  16 each  committed / dropped packet counters, saturating

## Operation
- Pointers: wr_ptr is the committed tail, cur_ptr is the working write pointer, head_ptr is the start of the oldest unretired packet. All are ADDR_W wide and wrap modulo 2^ADDR_W.
- used = cur_ptr - head_ptr (mod 2^ADDR_W). A beat may be written only when used != 2^ADDR_W-1. One slot is always kept empty.
- States:
  - IDLE: a sop beat with cfg_en=1 starts a packet.
    - If the descriptor FIFO is full, go to DROP.
    - Otherwise set base=cur_ptr and write the beat, then go to CAPT, or commit/discard at once if eop is on the same beat.
    - Beats without sop, and any beat with cfg_en=0, are ignored.
  - CAPT: each valid beat is written at cur_ptr, then cur_ptr increments.
    - When stored beats reach cfg_snap, go to SKIP.
    - If a write is blocked by a full ring, go to DROP.
  - SKIP: keep counting beats for length; write nothing; set trunc.
  - DROP: ignore beats until eop; at eop set cur_ptr=wr_ptr, increment drop_cnt, go to IDLE.
- Eop beat in CAPT or SKIP:
  - Filter pass: push descriptor {stat, trunc, len, base, end=next cur_ptr}, set wr_ptr=next cur_ptr, increment cap_cnt, go to IDLE.
  - Filter fail: set cur_ptr=wr_ptr with no count, go to IDLE.
- A sop arriving in CAPT or SKIP aborts the current packet: rollback, increment drop_cnt, then treat the beat as a new sop from IDLE.
- Length = (beats-1)*(DATA_W/8) + (in_mod==0 ? DATA_W/8 : in_mod), counting all received beats including skipped ones; saturates at 0xFFFF.
- info_pop with info_vald=1 sets head_ptr to the head descriptor's end and advances the FIFO. info_pop with info_vald=0 is ignored.
- cfg_mode, cfg_code and cfg_snap may change at any time; cfg_en is honoured at sop only.

## Timing
- Reset values: all outputs 0, state IDLE, all pointers 0, FIFO empty.
- Ring write is registered on the beat's clock edge.
- rd_data is valid one cycle after rd_buf; it holds its last value when rd_buf=0.
- Descriptor is visible (info_vald=1) in the cycle after the eop beat.
- A sop beat in the cycle immediately after eop is accepted (zero-gap).
- Pop effect: head_ptr and the info_* outputs update in the cycle after info_pop.
- Simultaneous pop and eop commit on an empty FIFO: the new descriptor appears the next cycle with the correct data.
- Free-space check uses registered head_ptr; space freed by a pop becomes usable the following cycle.
- rst_n asserted mid-packet: all state clears immediately; the partial packet is lost and no counter increments.

## Test plan
- ADDR_W=4, mode 01, three 3-beat packets with in_mod=2 (DATA_W=32) -> descriptors base 0/3/6, len 10 each, cap_cnt=3.
- Mode 00 with cfg_code=0x04; stat codes 0x04, 0x01, 0x04 -> two descriptors with base 0 and 3; ring reuses the rejected packet's space; drop_cnt=0.
- cfg_snap=2, 5-beat packet with in_mod=0 -> trunc=1, len=20, next packet base=2.
- ADDR_W=3, no pops, 4-beat packets -> first commits; second overflows at 3 free beats and is dropped (drop_cnt=1, cur_ptr back to 4); after a pop, the next packet commits at base 4 and wraps to address 0.
- Fill a 16-entry FIFO, then a sop -> packet dropped; sop after eop with zero gap accepted; sop mid-packet aborts it (drop_cnt increments).
- Assert rst_n mid-CAPT -> info_vald=0, counters 0, next packet base 0.
